// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD constants and BCD conversion helper
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1, ADJUST = 2'd2} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BLANK_DIGIT = 4'hF;
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: tick/control inputs and BCD digit/status outputs of the stopwatch
interface stopwatch_core_if;
  logic       tick_1hz, tick_2hz, tick_4hz, pause_p, adj, sel;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running, adjusting;
  modport master (output tick_1hz, tick_2hz, tick_4hz, pause_p, adj, sel,
                  input digit3, digit2, digit1, digit0, running, adjusting);
  modport slave  (input tick_1hz, tick_2hz, tick_4hz, pause_p, adj, sel,
                  output digit3, digit2, digit1, digit0, running, adjusting);
endinterface

// File: rtl/stopwatch_core_bcd2_counter.sv
// bcd2_counter: two-digit BCD counter wrapping to 00 after MAX, wrap pulses on inc at MAX
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o,
  output logic             wrap_o
);
  localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd2(MAX);
  logic [BCD_W-1:0] tens_q, tens_d, ones_q, ones_d;
  logic at_max;
  assign at_max = {tens_q, ones_q} == MAX_BCD;
  assign wrap_o = inc & at_max;
  // ones roll 9->0 carrying into tens; whole field returns to 00 past MAX
  always_comb begin
    ones_d = (clr | (inc & (at_max | ones_q == 4'd9))) ? '0 : ones_q + 4'(inc);
    tens_d = (clr | (inc & at_max)) ? '0 : tens_q + 4'(inc & (ones_q == 4'd9));
  end
  // digit registers
  always_ff @(posedge clk) begin
    tens_q <= tens_d;
    ones_q <= ones_d;
  end
  assign tens_o = tens_q;
  assign ones_o = ones_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch with run/pause/adjust; STOPWATCH_BLINK_EN enables adjust-field blinking
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input logic              clk,
  input logic              rst,
  stopwatch_core_if.slave  bus
);
  state_t state_q, state_d;
  logic paused_q, paused_d;
  logic run_tick, adj_tick, sec_inc, min_inc, sec_wrap, unused_min_wrap;
  logic blank_min, blank_sec;
  logic [BCD_W-1:0] min_t, min_o, sec_t, sec_o;
  assign run_tick = (state_q == RUN) & bus.tick_1hz;
  assign adj_tick = (state_q == ADJUST) & bus.tick_2hz;
  assign sec_inc  = run_tick | (adj_tick & bus.sel);
  assign min_inc  = (run_tick & sec_wrap) | (adj_tick & ~bus.sel);
  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .clr(rst), .inc(sec_inc), .tens_o(sec_t), .ones_o(sec_o), .wrap_o(sec_wrap)
  );
  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .clr(rst), .inc(min_inc), .tens_o(min_t), .ones_o(min_o), .wrap_o(unused_min_wrap)
  );
  // paused flag toggles on every pause_p; outside ADJUST it alone picks RUN vs PAUSE
  always_comb begin
    paused_d = rst ? 1'b0 : paused_q ^ bus.pause_p;
    state_d  = rst ? RUN : bus.adj ? ADJUST : paused_d ? PAUSE : RUN;
  end
  // state and paused flag registers
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    paused_q <= paused_d;
  end
`ifdef STOPWATCH_BLINK_EN
  logic blink_q, blink_d;
  // phase is held at 0 outside ADJUST so every ADJUST entry starts unblanked
  always_comb blink_d = (rst | state_q != ADJUST) ? 1'b0 : blink_q ^ bus.tick_4hz;
  // blink phase register
  always_ff @(posedge clk) blink_q <= blink_d;
  assign blank_min = (state_q == ADJUST) & blink_q & ~bus.sel;
  assign blank_sec = (state_q == ADJUST) & blink_q & bus.sel;
`else
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif
  assign bus.digit3    = blank_min ? BLANK_DIGIT : min_t;
  assign bus.digit2    = blank_min ? BLANK_DIGIT : min_o;
  assign bus.digit1    = blank_sec ? BLANK_DIGIT : sec_t;
  assign bus.digit0    = blank_sec ? BLANK_DIGIT : sec_o;
  assign bus.running   = state_q == RUN;
  assign bus.adjusting = state_q == ADJUST;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scoreboard bench for stopwatch_core
module tb_stopwatch_core;
  typedef struct {
    string       nm;
    logic [17:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [17:0] act;
  stopwatch_core_if sw_if ();
  stopwatch_core dut (.clk(clk), .rst(rst), .bus(sw_if));
  always #10 clk = ~clk;
  // monitor: outputs are stable mid-cycle, compare against oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {sw_if.digit3, sw_if.digit2, sw_if.digit1, sw_if.digit0, sw_if.running, sw_if.adjusting};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got digits=%h run=%b adj=%b, expected digits=%h run=%b adj=%b",
                 e.nm, act[17:2], act[1], act[0], e.v[17:2], e.v[1], e.v[0]);
      end
    end
  end
  task automatic expect_out(input string nm, input logic [15:0] d, input logic r, input logic a);
    exp_t x;
    x.nm = nm;
    x.v  = {d, r, a};
    exp_q.push_back(x);
  endtask
  task automatic cyc(input logic t1, input logic t2, input logic t4, input logic pp);
    sw_if.tick_1hz = t1;
    sw_if.tick_2hz = t2;
    sw_if.tick_4hz = t4;
    sw_if.pause_p  = pp;
    @(posedge clk);
    #1;
    sw_if.tick_1hz = 1'b0;
    sw_if.tick_2hz = 1'b0;
    sw_if.tick_4hz = 1'b0;
    sw_if.pause_p  = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask
  task automatic adj_ticks(input logic s, input int n);
    sw_if.sel = s;
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask
  initial begin
    sw_if.tick_1hz = 1'b0;
    sw_if.tick_2hz = 1'b0;
    sw_if.tick_4hz = 1'b0;
    sw_if.pause_p  = 1'b0;
    sw_if.adj      = 1'b0;
    sw_if.sel      = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    expect_out("reset", 16'h0000, 1, 0);
    cyc(1, 0, 0, 0); expect_out("run_t1", 16'h0001, 1, 0);
    cyc(1, 0, 0, 0); expect_out("run_t2", 16'h0002, 1, 0);
    cyc(1, 0, 0, 0); expect_out("run_t3", 16'h0003, 1, 0);
    sw_if.adj = 1'b1;
    cyc(0, 0, 0, 0); expect_out("enter_adj", 16'h0003, 0, 1);
    adj_ticks(0, 59);
    adj_ticks(1, 56); expect_out("preload_5959", 16'h5959, 0, 1);
    sw_if.adj = 1'b0;
    cyc(0, 0, 0, 0); expect_out("leave_adj", 16'h5959, 1, 0);
    cyc(1, 0, 0, 0); expect_out("wrap_0000", 16'h0000, 1, 0);
    sw_if.adj = 1'b1;
    cyc(0, 0, 0, 0);
    adj_ticks(0, 9);
    adj_ticks(1, 59); expect_out("preload_0959", 16'h0959, 0, 1);
    sw_if.adj = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); expect_out("carry_1000", 16'h1000, 1, 0);
    cyc(0, 0, 0, 1); expect_out("pause", 16'h1000, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    expect_out("paused_ticks", 16'h1000, 0, 0);
    cyc(0, 0, 0, 1); expect_out("resume", 16'h1000, 1, 0);
    cyc(1, 0, 0, 0); expect_out("resume_tick", 16'h1001, 1, 0);
    do_reset(); expect_out("reset2", 16'h0000, 1, 0);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    expect_out("adj_min3", 16'h0300, 0, 1);
    adj_ticks(1, 60); expect_out("adj_sec60", 16'h0300, 0, 1);
    sw_if.adj = 1'b0;
    cyc(0, 0, 0, 0); expect_out("adj_exit", 16'h0300, 1, 0);
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
    expect_out("at_0007", 16'h0007, 1, 0);
    cyc(1, 0, 0, 1); expect_out("tick_and_pause", 16'h0008, 0, 0);
    cyc(1, 0, 0, 1); expect_out("unpause_tick", 16'h0008, 1, 0);
    sw_if.adj = 1'b1;
    cyc(1, 0, 0, 0); expect_out("adj_rise_tick", 16'h0009, 0, 1);
    adj_ticks(1, 1); expect_out("adj_sec_inc", 16'h0010, 0, 1);
    do_reset(); expect_out("rst_mid_adj", 16'h0000, 1, 0);
    cyc(0, 0, 0, 0); expect_out("adj_after_rst", 16'h0000, 0, 1);
    cyc(0, 0, 0, 1); expect_out("pause_in_adj", 16'h0000, 0, 1);
    sw_if.adj = 1'b0;
    cyc(0, 0, 0, 0); expect_out("exit_to_pause", 16'h0000, 0, 0);
    do_reset();
    sw_if.adj = 1'b1;
    cyc(0, 0, 0, 0);
    adj_ticks(0, 12);
    adj_ticks(1, 34); expect_out("preload_1234", 16'h1234, 0, 1);
`ifdef STOPWATCH_BLINK_EN
    cyc(0, 0, 1, 0); expect_out("blink_on", 16'h12FF, 0, 1);
`else
    cyc(0, 0, 1, 0); expect_out("blink_on", 16'h1234, 0, 1);
`endif
    cyc(0, 0, 1, 0); expect_out("blink_off", 16'h1234, 0, 1);
    sw_if.adj = 1'b0;
    cyc(0, 0, 1, 0); expect_out("run_4hz", 16'h1234, 1, 0);
    cyc(0, 1, 0, 0); expect_out("run_2hz_ignored", 16'h1234, 1, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
